// File: rtl/misr_param.sv
// Parametrised multiple-input signature register with pattern counting and
// golden-signature compare, used to compact BIST responses into one word.
module misr_param #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] POLY   = 8'h1D,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int              COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [COUNT_W-1:0] n_patterns,
  input  logic [WIDTH-1:0]   e,
  input  logic               e_valid,
  input  logic [WIDTH-1:0]   golden,
  output logic [WIDTH-1:0]   sig,
  output logic               busy,
  output logic               done,
  output logic               pass
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [COUNT_W-1:0] cnt;

  // Galois step: shift left, fold the outgoing MSB back through the tap mask,
  // then absorb the response word.
  function automatic logic [WIDTH-1:0] next_sig(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] fb;
    fb = s[WIDTH-1] ? POLY : '0;
    return {s[WIDTH-2:0], 1'b0} ^ fb ^ d;
  endfunction

  // NOTE: every register in this block is written with <= so all of them
  // update from the pre-edge values, exactly like the hardware flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      sig   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      // NOTE: done defaults low every cycle so it can only ever be a pulse.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sig   <= SEED;
            cnt   <= n_patterns;
            pass  <= 1'b0;
            state <= (n_patterns != '0) ? ST_COMPACT : ST_DONE;
          end
        end
        ST_COMPACT: begin
          // Beats arrive only on e_valid; stalls hold both signature and count.
          if (e_valid) begin
            sig <= next_sig(sig, e);
            cnt <= cnt - 1'b1;
            if (cnt == COUNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          pass  <= (sig == golden);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_misr_param.sv
// Self-checking bench for misr_param: per-cycle comparison against a
// behavioural signature model plus directed literal expectations.
module tb_misr_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  start;
  logic [15:0] n_pat;
  logic [15:0] e;
  logic        e_valid;
  logic [15:0] golden;

  logic [7:0]  sig_a, sig_b, sig_c;
  logic [15:0] sig_d;
  logic [15:0] sig_o  [4];
  logic        busy_o [4];
  logic        done_o [4];
  logic        pass_o [4];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 CLK = ~CLK;

  misr_param #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .COUNT_W(16)) u0 (
    .CLK(CLK), .RST(RST), .start(start[0]), .n_patterns(n_pat), .e(e[7:0]),
    .e_valid(e_valid), .golden(golden[7:0]), .sig(sig_a), .busy(busy_o[0]),
    .done(done_o[0]), .pass(pass_o[0]));

  misr_param #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h80), .COUNT_W(16)) u1 (
    .CLK(CLK), .RST(RST), .start(start[1]), .n_patterns(n_pat), .e(e[7:0]),
    .e_valid(e_valid), .golden(golden[7:0]), .sig(sig_b), .busy(busy_o[1]),
    .done(done_o[1]), .pass(pass_o[1]));

  misr_param #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h5A), .COUNT_W(16)) u2 (
    .CLK(CLK), .RST(RST), .start(start[2]), .n_patterns(n_pat), .e(e[7:0]),
    .e_valid(e_valid), .golden(golden[7:0]), .sig(sig_c), .busy(busy_o[2]),
    .done(done_o[2]), .pass(pass_o[2]));

  misr_param #(.WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF), .COUNT_W(16)) u3 (
    .CLK(CLK), .RST(RST), .start(start[3]), .n_patterns(n_pat), .e(e),
    .e_valid(e_valid), .golden(golden), .sig(sig_d), .busy(busy_o[3]),
    .done(done_o[3]), .pass(pass_o[3]));

  assign sig_o[0] = {8'h00, sig_a};
  assign sig_o[1] = {8'h00, sig_b};
  assign sig_o[2] = {8'h00, sig_c};
  assign sig_o[3] = sig_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned wid(input int k);
    return (k == 3) ? 16 : 8;
  endfunction

  function automatic int unsigned poly(input int k);
    return (k == 3) ? 32'h1021 : 32'h1D;
  endfunction

  function automatic int unsigned seed(input int k);
    case (k)
      0:       return 32'h00;
      1:       return 32'h80;
      2:       return 32'h5A;
      default: return 32'hFFFF;
    endcase
  endfunction

  // Multiply the signature polynomial by x modulo the feedback polynomial, add e.
  function automatic int unsigned nxt(input int k, input int unsigned s, input int unsigned d);
    int unsigned mask;
    int unsigned t;
    mask = (32'd1 << wid(k)) - 1;
    t = s << 1;
    if (((s >> (wid(k) - 1)) & 1) != 0) t = t ^ poly(k);
    return (t ^ d) & mask;
  endfunction

  int unsigned m_sig  [4];
  int unsigned m_rem  [4];
  bit          m_run  [4];   // still collecting beats
  bit          m_rep  [4];   // signature final, verdict due at next edge
  bit          m_done [4];
  bit          m_pass [4];

  always @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      m_done[k] <= 1'b0;
      if (RST) begin
        m_sig[k] <= 0; m_rem[k] <= 0; m_run[k] <= 0; m_rep[k] <= 0; m_pass[k] <= 0;
      end else if (m_rep[k]) begin
        m_done[k] <= 1'b1;
        m_pass[k] <= (m_sig[k] == ((k == 3) ? 32'(golden) : 32'(golden[7:0])));
        m_rep[k]  <= 1'b0;
      end else if (m_run[k]) begin
        if (e_valid) begin
          m_sig[k] <= nxt(k, m_sig[k], (k == 3) ? 32'(e) : 32'(e[7:0]));
          m_rem[k] <= m_rem[k] - 1;
          if (m_rem[k] == 1) begin
            m_run[k] <= 1'b0;
            m_rep[k] <= 1'b1;
          end
        end
      end else if (start[k]) begin
        m_sig[k]  <= seed(k);
        m_rem[k]  <= 32'(n_pat);
        m_pass[k] <= 1'b0;
        m_run[k]  <= (n_pat != 0);
        m_rep[k]  <= (n_pat == 0);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("u%0d.sig", k),  32'(sig_o[k]),  m_sig[k]);
        check($sformatf("u%0d.busy", k), 32'(busy_o[k]), 32'(m_run[k] || m_rep[k]));
        check($sformatf("u%0d.done", k), 32'(done_o[k]), 32'(m_done[k]));
        check($sformatf("u%0d.pass", k), 32'(pass_o[k]), 32'(m_pass[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input int k, input logic [15:0] n);
    start[k] = 1'b1;
    n_pat    = n;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic beat(input logic [15:0] v);
    e       = v;
    e_valid = 1'b1;
    tick();
    e_valid = 1'b0;
  endtask

  // Standard three-beat run on u0 with idle gaps between beats.
  task automatic run_basic(input logic [7:0] gold, input bit exp_pass, input string tag);
    golden = {8'h00, gold};
    do_start(0, 16'd3);
    beat(16'h01); check({tag, ".sig1"}, 32'(sig_a), 32'h01);
    tick();
    beat(16'h80); check({tag, ".sig2"}, 32'(sig_a), 32'h82);
    tick(); tick();
    beat(16'h00); check({tag, ".sig3"}, 32'(sig_a), 32'h19);
    check({tag, ".busy_done_state"}, 32'(busy_o[0]), 32'h1);
    tick();
    check({tag, ".done"}, 32'(done_o[0]), 32'h1);
    check({tag, ".pass"}, 32'(pass_o[0]), 32'(exp_pass));
    tick();
    check({tag, ".done_low"}, 32'(done_o[0]), 32'h0);
    check({tag, ".busy_low"}, 32'(busy_o[0]), 32'h0);
    check({tag, ".sig_hold"}, 32'(sig_a), 32'h19);
  endtask

  logic [15:0] rnd_e  [1000];
  bit          rnd_gap[1000];

  initial begin
    int unsigned exp_sig;
    bit          seen;

    RST = 1'b1; start = '0; n_pat = '0; e = '0; e_valid = 1'b0; golden = '0;
    tick(); tick();
    RST = 1'b0;
    chk_en = 1'b1;
    check("reset.sig",  32'(sig_a),     32'h0);
    check("reset.busy", 32'(busy_o[0]), 32'h0);
    check("reset.done", 32'(done_o[0]), 32'h0);
    check("reset.pass", 32'(pass_o[0]), 32'h0);

    // Basic compaction, matching and mismatching golden.
    run_basic(8'h19, 1'b1, "basic_pass");
    run_basic(8'h18, 1'b0, "basic_fail");

    // Single beat from seed 80: MSB folds back through the taps.
    golden = 16'h001D;
    do_start(1, 16'd1);
    check("seed80.sig_seed", 32'(sig_b), 32'h80);
    beat(16'h00);
    check("seed80.sig", 32'(sig_b), 32'h1D);
    tick();
    check("seed80.done", 32'(done_o[1]), 32'h1);
    tick();
    check("seed80.busy_low", 32'(busy_o[1]), 32'h0);
    check("seed80.done_low", 32'(done_o[1]), 32'h0);

    // Zero-length run reports the seed immediately; beats in flight are ignored.
    golden = 16'h005A;
    e = 16'hFF; e_valid = 1'b1;
    do_start(2, 16'd0);
    check("zero.busy", 32'(busy_o[2]), 32'h1);
    tick();
    e_valid = 1'b0;
    check("zero.done", 32'(done_o[2]), 32'h1);
    check("zero.pass", 32'(pass_o[2]), 32'h1);
    check("zero.sig",  32'(sig_c),     32'h5A);

    // Restart attempt mid-run must be ignored.
    golden = 16'h0019;
    do_start(0, 16'd3);
    beat(16'h01);
    do_start(0, 16'd7);
    beat(16'h80);
    beat(16'h00);
    check("restart.sig", 32'(sig_a), 32'h19);
    tick();
    check("restart.done", 32'(done_o[0]), 32'h1);
    check("restart.pass", 32'(pass_o[0]), 32'h1);
    // Back-to-back: new start accepted while done is high clears pass.
    do_start(0, 16'd4);
    check("b2b.pass_cleared", 32'(pass_o[0]), 32'h0);
    check("b2b.busy", 32'(busy_o[0]), 32'h1);

    // Reset after two of four beats aborts the run without a done pulse.
    beat(16'h01);
    beat(16'h80);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst.sig",  32'(sig_a),     32'h0);
    check("rst.busy", 32'(busy_o[0]), 32'h0);
    check("rst.done", 32'(done_o[0]), 32'h0);
    check("rst.pass", 32'(pass_o[0]), 32'h0);
    tick(); tick();
    check("rst.no_done", 32'(done_o[0]), 32'h0);
    run_basic(8'h19, 1'b1, "after_rst");

    // 16-bit CCITT-style run: 1000 random beats with random stalls.
    exp_sig = 32'hFFFF;
    for (int i = 0; i < 1000; i++) begin
      rnd_e[i]   = 16'($urandom);
      rnd_gap[i] = ($urandom_range(0, 3) == 0);
      exp_sig    = nxt(3, exp_sig, 32'(rnd_e[i]));
    end
    golden = exp_sig[15:0];
    do_start(3, 16'd1000);
    for (int i = 0; i < 1000; i++) begin
      if (rnd_gap[i]) begin
        e = 16'($urandom);
        tick();
      end
      beat(rnd_e[i]);
    end
    check("w16.sig_final", 32'(sig_d), exp_sig);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (done_o[3]) seen = 1'b1;
    end
    check("w16.done_seen", 32'(seen), 32'h1);
    check("w16.pass", 32'(pass_o[3]), 32'h1);

    // Longest run: 2^16-1 beats must finish without the counter wrapping.
    golden = 16'h0000;
    do_start(1, 16'hFFFF);
    e = 16'h0000; e_valid = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check("max.busy_before_last", 32'(busy_o[1]), 32'h1);
    tick();
    e_valid = 1'b0;
    tick();
    check("max.done", 32'(done_o[1]), 32'h1);
    tick();
    check("max.busy_low", 32'(busy_o[1]), 32'h0);

    chk_en = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/misr_param.md
# misr_param

Parametrised multiple-input signature register (MISR) with built-in pattern counting and golden-signature compare, for BIST response compaction. A test controller starts a compaction run, the circuit-under-test drives one WIDTH-bit response word per valid beat, and after the programmed number of beats the block reports done and pass/fail. It supersedes the fixed-width, free-running, reset-less compactor: width, feedback polynomial, seed and run length are all configurable, and input can stall.

## Interface
Parameters:
- WIDTH, 8: signature and response width, ≥ 2.
- POLY, 8'h1D: feedback tap mask, WIDTH bits; bit i set → XOR feedback into bit i.
- SEED, 0: signature value loaded on start.
- COUNT_W, 16: width of pattern counter.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  begin run; honoured only in IDLE.
- n_patterns  in  COUNT_W  beats to compact; sampled on accepted start.
- e  in  WIDTH  response word from circuit-under-test.
- e_valid  in  1  e is valid this cycle; compacted only in COMPACT.
- golden  in  WIDTH  expected signature; sampled in DONE state.
- sig  out  WIDTH  current signature register.
- busy  out  1  high in COMPACT and DONE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result of last run; held until next start or RST.

## Operation
- States: IDLE, COMPACT, DONE. Reset state IDLE.
- IDLE: start=1 → sig<=SEED, cnt<=n_patterns, pass<=0; go COMPACT if n_patterns≠0, else go DONE directly (signature = SEED).
- COMPACT: per cycle with e_valid=1: sig<=next(sig,e), cnt<=cnt−1; if cnt==1 go DONE. e_valid=0 → sig, cnt hold (stall, no limit).
- next(s,e) = ({s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? POLY : 0)) ^ e. Internal-XOR (Galois) form; all arithmetic mod 2, truncated to WIDTH.
- DONE: done<=1, pass<=(sig==golden), go IDLE. sig holds.
- start while busy: ignored (no restart, no count reload).
- e/e_valid in IDLE or DONE: ignored.
- sig holds final signature in IDLE until next accepted start.

## Timing
- RST at edge: state=IDLE, sig=0, cnt=0, busy=0, done=0, pass=0 after that edge; overrides start and any run in progress (run aborted, no done pulse).
- start accepted at edge t0 → sig=SEED and busy=1 from t0; first beat may be compacted at edge t0+1.
- Final beat accepted at edge tk → sig final and state DONE after tk; at edge tk+1 done=1 and pass valid; at edge tk+2 done=0, busy=0.
- n_patterns=0: start at t0 → DONE; done=1 after t0+1.
- done is high exactly one cycle per completed run; back-to-back runs: start may be accepted the cycle done is high (state already IDLE), pass cleared at that edge.
- n_patterns = 2^COUNT_W−1 must complete without counter wrap.

## Test plan
- WIDTH=8, POLY=8'h1D, SEED=0, n_patterns=3, beats e=01,80,00 (with e_valid gaps between) → sig after each beat 01,82,19; golden=8'h19 → done one pulse, pass=1; golden=8'h18 → pass=0.
- SEED=8'h80, n_patterns=1, e=00 → sig=8'h1D, done pulse, busy low two edges after the beat.
- n_patterns=0, SEED=8'h5A, golden=8'h5A → done one cycle after start, pass=1, sig=5A, no beats consumed.
- start pulsed again mid-COMPACT with different n_patterns → ignored; run finishes on original count with same signature as undisturbed run.
- RST asserted mid-COMPACT (after 2 of 4 beats) → next edge sig=0, busy=0, done=0, pass=0; no done pulse; fresh start then completes normally.
- WIDTH=16, POLY=16'h1021, SEED=16'hFFFF, 1000 random beats vs bench software model → sig matches model every cycle, done/pass correct.
